branch_hazard_ctrl: RTL
=======================

Name: branch_hazard_ctrl

Overview:
- Sequences ID-stage branch resolution in the 5-stage pipeline.
- Detects RAW hazards on the branch comparator operands and stalls PC and IF/ID for 1 or 2 cycles, injecting bubbles into ID/EX.
- Once operands are safe, samples the comparator's taken flag, redirects the PC and flushes IF/ID.
- Keeps saturating performance counters for branches, taken branches and stall cycles.

Parameters:
- REG_W, 5, register-index width
- CNT_W, 16, width of each performance counter

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_branch  input  3  ID branch type: 000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110/111 treated as none
- i_rs  input  REG_W  ID source register 1
- i_rt  input  REG_W  ID source register 2; used only by beq/bne
- i_ex_regwrite  input  1  EX-stage instruction writes a register
- i_ex_memread  input  1  EX-stage instruction is a load
- i_ex_rd  input  REG_W  EX-stage destination
- i_mem_memread  input  1  MEM-stage instruction is a load
- i_mem_rd  input  REG_W  MEM-stage destination
- i_taken  input  1  comparator result for the current ID operands
- i_cancel  input  1  kill in-flight branch handling (exception/jump from a later stage)
- o_stall  output  1  hold PC and IF/ID
- o_bubble  output  1  zero ID/EX control signals
- o_pc_sel  output  1  select branch target for the next PC
- o_flush_ifid  output  1  clear IF/ID at the next edge
- o_branch_cnt  output  CNT_W  resolved branches
- o_taken_cnt  output  CNT_W  taken branches
- o_stall_cnt  output  CNT_W  stall cycles

Behaviour:
- Branch is valid when i_branch is in 001..101. Operand set is {rs, rt} for beq/bne and {rs} otherwise. Register 0 is never a hazard.
- need is computed in IDLE:
  - 2 if i_ex_regwrite && i_ex_memread && i_ex_rd matches an operand.
  - Else 1 if (i_ex_regwrite && i_ex_rd matches) or (i_mem_memread && i_mem_rd matches).
  - Else 0.
- FSM states: IDLE, STALL2. Reset state is IDLE.
- IDLE, valid branch, need=0 (resolve cycle):
  - Outputs combinational: o_pc_sel = o_flush_ifid = i_taken; o_stall = o_bubble = 0.
  - o_branch_cnt +1; o_taken_cnt +1 if i_taken. State stays IDLE.
- IDLE, valid branch, need=1: o_stall = o_bubble = 1, o_pc_sel = o_flush_ifid = 0, o_stall_cnt +1. State stays IDLE; re-evaluation next cycle resolves.
- IDLE, valid branch, need=2: same outputs as need=1, next state STALL2.
- STALL2: o_stall = o_bubble = 1 unconditionally, o_stall_cnt +1, hazard inputs and i_taken ignored. Next state IDLE.
- No valid branch in IDLE: all control outputs 0, counters unchanged.
- i_cancel (priority over everything):
  - All control outputs forced 0 that cycle, next state IDLE.
  - No counter updates that cycle, including a would-be resolve.
- Counters saturate at all-ones and never wrap.
- Reset values: all counters 0, state IDLE, so all control outputs are 0 during and after reset.
- Reset asserted mid-stall: state returns to IDLE immediately (asynchronous); o_stall drops in the same cycle.
- Latency:
  - Branch with no hazard resolves in its first ID cycle.
  - Total stall cycles for a branch are 1 (ALU producer in EX, or load in MEM) or 2 (load in EX).
  - Flush is exactly one cycle per taken branch.
- Simultaneous EX and MEM matches: the larger need wins (EX load gives 2).

Test Plan:
- Reset held 3 cycles, then beq r1,r2 with no hazards and i_taken=1 → o_pc_sel = o_flush_ifid = 1 for 1 cycle, o_stall = 0, branch_cnt=1, taken_cnt=1.
- bne r3,r4 with EX ALU writing r4 → 1 stall cycle (o_stall = o_bubble = 1), then resolve with i_taken=0 → no flush, stall_cnt=1, branch_cnt=1, taken_cnt=0.
- bgtz r5 with EX load writing r5 → 2 stall cycles (second in STALL2 while inputs change), then resolve taken → flush; stall_cnt=2.
- blez r0 with EX writing r0, and beq r6,r7 with rt hazard only on blez-style rs-only type (bltz r6 with EX rd=r7) → no stall in both cases.
- Load-in-EX hazard, assert i_cancel in the STALL2 cycle → outputs 0, IDLE next, branch_cnt unchanged; separately, i_rst pulsed mid-STALL2 → o_stall deasserts immediately, counters 0.
- CNT_W=4: 17 taken branches without hazards → taken_cnt = branch_cnt = 15 (saturated).

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// branch_hazard_ctrl
//
// Controls branch resolution in the ID stage of a 5-stage pipeline.
//   - Checks the branch comparator operands for RAW hazards against the
//     producers in EX and MEM. When a hazard is found it stalls the PC and
//     IF/ID for one or two cycles and injects bubbles into ID/EX.
//   - When the operands are safe it takes the comparator's taken flag, selects
//     the branch target for the next PC, and flushes IF/ID.
//   - Keeps saturating performance counters for resolved branches, taken
//     branches and stall cycles.
//
// Parameters
//   REG_W          register-index width
//   CNT_W          width of each performance counter
//
// Ports
//   i_clk          clock; all state updates happen on the rising edge
//   i_rst          asynchronous active-high reset
//   i_branch       ID branch type (001 beq, 010 bne, 011 blez, 100 bgtz,
//                  101 bltz; any other value means no branch)
//   i_rs, i_rt     ID source registers (i_rt is used only by beq/bne)
//   i_ex_regwrite  the EX-stage instruction writes a register
//   i_ex_memread   the EX-stage instruction is a load
//   i_ex_rd        EX-stage destination register
//   i_mem_memread  the MEM-stage instruction is a load
//   i_mem_rd       MEM-stage destination register
//   i_taken        comparator result for the current ID operands
//   i_cancel       kills in-flight branch handling (from a later stage)
//   o_stall        hold PC and IF/ID
//   o_bubble       zero the ID/EX control signals
//   o_pc_sel       select the branch target for the next PC
//   o_flush_ifid   clear IF/ID at the next edge
//   o_branch_cnt   number of resolved branches (saturating)
//   o_taken_cnt    number of taken branches (saturating)
//   o_stall_cnt    number of stall cycles (saturating)
// -----------------------------------------------------------------------------
module branch_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_branch,
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rt,
    input  logic             i_ex_regwrite,
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_mem_memread,
    input  logic [REG_W-1:0] i_mem_rd,
    input  logic             i_taken,
    input  logic             i_cancel,
    output logic             o_stall,
    output logic             o_bubble,
    output logic             o_pc_sel,
    output logic             o_flush_ifid,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_taken_cnt,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STALL2 = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic branch_valid;
    logic uses_rt;
    logic ex_match;
    logic mem_match;
    logic need2;
    logic need1;

    logic stall_c;
    logic bubble_c;
    logic pc_sel_c;
    logic flush_c;
    logic inc_branch;
    logic inc_taken;
    logic inc_stall;

    // Branch decode: beq/bne compare rs with rt; the others compare rs with zero.
    always_comb begin
        branch_valid = 1'b0;
        uses_rt      = 1'b0;
        case (i_branch)
            3'b001, 3'b010: begin
                branch_valid = 1'b1;
                uses_rt      = 1'b1;
            end
            3'b011, 3'b100, 3'b101: begin
                branch_valid = 1'b1;
            end
            default: begin
                branch_valid = 1'b0;
                uses_rt      = 1'b0;
            end
        endcase
    end

    // A destination register of r0 never creates a hazard, whatever the operands are.
    always_comb begin
        ex_match  = (i_ex_rd != '0) &&
                    ((i_ex_rd == i_rs) || (uses_rt && (i_ex_rd == i_rt)));
        mem_match = (i_mem_rd != '0) &&
                    ((i_mem_rd == i_rs) || (uses_rt && (i_mem_rd == i_rt)));
    end

    // A load in EX needs two cycles, so it takes priority over the one-cycle cases.
    always_comb begin
        need2 = i_ex_regwrite && i_ex_memread && ex_match;
        need1 = (i_ex_regwrite && ex_match) || (i_mem_memread && mem_match);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        stall_c    = 1'b0;
        bubble_c   = 1'b0;
        pc_sel_c   = 1'b0;
        flush_c    = 1'b0;
        inc_branch = 1'b0;
        inc_taken  = 1'b0;
        inc_stall  = 1'b0;

        if (i_cancel) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (branch_valid) begin
                        if (need2) begin
                            stall_c   = 1'b1;
                            bubble_c  = 1'b1;
                            inc_stall = 1'b1;
                            state_nxt = ST_STALL2;
                        end else if (need1) begin
                            // Stay in IDLE; the next cycle re-evaluates and resolves.
                            stall_c   = 1'b1;
                            bubble_c  = 1'b1;
                            inc_stall = 1'b1;
                        end else begin
                            pc_sel_c   = i_taken;
                            flush_c    = i_taken;
                            inc_branch = 1'b1;
                            inc_taken  = i_taken;
                        end
                    end
                end
                ST_STALL2: begin
                    // The load is now in MEM; the operands are not safe yet, whatever the inputs show.
                    stall_c   = 1'b1;
                    bubble_c  = 1'b1;
                    inc_stall = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Gate with reset so that a hazard present in the ID-stage inputs cannot
    // assert controls while reset is held.
    always_comb begin
        o_stall      = stall_c  && !i_rst;
        o_bubble     = bubble_c && !i_rst;
        o_pc_sel     = pc_sel_c && !i_rst;
        o_flush_ifid = flush_c  && !i_rst;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_branch_cnt <= '0;
            o_taken_cnt  <= '0;
            o_stall_cnt  <= '0;
        end else begin
            if (inc_branch && (o_branch_cnt != '1)) begin
                o_branch_cnt <= o_branch_cnt + CNT_W'(1);
            end
            if (inc_taken && (o_taken_cnt != '1)) begin
                o_taken_cnt <= o_taken_cnt + CNT_W'(1);
            end
            if (inc_stall && (o_stall_cnt != '1)) begin
                o_stall_cnt <= o_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
